// File: rtl/down_timer_pkg.sv
// down_timer_pkg: state encoding and default counter width shared by down_timer and down_timer_fsm
package down_timer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEFAULT_WIDTH = 4;
endpackage

// File: rtl/down_timer_fsm.sv
// down_timer_fsm: IDLE/RUN/DONE sequencing (load over en), Moore busy/done; ports clk reset load en in_zero out_one reload_nz -> state busy done
module down_timer_fsm
  import down_timer_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  logic   en,
  input  logic   in_zero,
  input  logic   out_one,
  input  logic   reload_nz,
  output state_t state,
  output logic   busy,
  output logic   done
);
  state_t state_nxt;
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    if (load) state_nxt = in_zero ? DONE : RUN;
    else if (state == RUN) state_nxt = (en && out_one) ? DONE : RUN;
    else if (state == DONE) state_nxt = reload_nz ? RUN : IDLE;
  end
  assign busy = (state == RUN);
  assign done = (state == DONE);
endmodule

// File: rtl/down_timer.sv
// down_timer: loadable down counter with single-cycle done pulse; ports clk reset en load in -> out busy done; DOWN_TIMER_AUTO_RELOAD_EN adds reload register
module down_timer
  import down_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);
  state_t state;
  logic   reload_nz;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload;
  always_ff @(posedge clk)
    if (reset) reload <= '0;
    else if (load) reload <= in;
  assign reload_nz = |reload;
`else
  assign reload_nz = 1'b0;
`endif
  down_timer_fsm u_fsm (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .en       (en),
    .in_zero  (~|in),
    .out_one  (out == WIDTH'(1)),
    .reload_nz(reload_nz),
    .state    (state),
    .busy     (busy),
    .done     (done)
  );
  always_ff @(posedge clk)
    if (reset) out <= '0;
    else if (load) out <= in;
    else if (state == RUN && en) out <= out - WIDTH'(1);
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    else if (state == DONE && reload_nz) out <= reload;
`endif
endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: directed vectors feed a per-cycle expected queue; a monitor pops and compares out/busy/done
module tb_down_timer;
  typedef struct {
    logic [3:0] o;
    logic       b;
    logic       d;
    string      nm;
  } exp_t;
  logic       clk = 0;
  logic       reset = 1;
  logic       en = 0;
  logic       load = 0;
  logic [3:0] in = 0;
  logic [3:0] out;
  logic       busy;
  logic       done;
  exp_t       q[$];
  int         checks = 0;
  int         passed = 0;
  down_timer #(.WIDTH(4)) dut (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .load (load),
    .in   (in),
    .out  (out),
    .busy (busy),
    .done (done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (out === e.o && busy === e.b && done === e.d) passed++;
      else $display("FAIL %s: got out=%0d busy=%b done=%b, expected out=%0d busy=%b done=%b",
                    e.nm, out, busy, done, e.o, e.b, e.d);
    end
  end
  task automatic step(input logic r, input logic l, input logic e, input logic [3:0] i,
                      input logic [3:0] eo, input logic eb, input logic ed, input string nm);
    exp_t x;
    @(negedge clk);
    reset = r;
    load  = l;
    en    = e;
    in    = i;
    x.o = eo;
    x.b = eb;
    x.d = ed;
    x.nm = nm;
    q.push_back(x);
  endtask
  initial begin
    int guard;
    step(1, 0, 0, 0, 0, 0, 0, "reset");
    step(1, 1, 1, 7, 0, 0, 0, "reset_over_load");
    step(0, 1, 1, 4, 4, 1, 0, "load4");
    step(0, 0, 1, 0, 3, 1, 0, "cnt3");
    step(0, 0, 1, 0, 2, 1, 0, "cnt2");
    step(0, 0, 1, 0, 1, 1, 0, "cnt1");
    step(0, 0, 1, 0, 0, 0, 1, "cnt0_done");
    step(1, 0, 0, 0, 0, 0, 0, "rst_after_done");
    step(0, 1, 1, 3, 3, 1, 0, "load3");
    step(0, 0, 1, 0, 2, 1, 0, "p_en1");
    step(0, 0, 0, 0, 2, 1, 0, "p_pause1");
    step(0, 0, 0, 0, 2, 1, 0, "p_pause2");
    step(0, 0, 1, 0, 1, 1, 0, "p_en_a");
    step(0, 0, 1, 0, 0, 0, 1, "p_done");
    step(1, 0, 0, 0, 0, 0, 0, "rst_p");
    step(0, 1, 0, 0, 0, 0, 1, "zero_load_done");
    step(0, 0, 1, 0, 0, 0, 0, "zero_load_idle");
    step(0, 1, 0, 0, 0, 0, 1, "zero_load_again");
    step(0, 1, 0, 3, 3, 1, 0, "load_in_done");
    step(1, 0, 0, 0, 0, 0, 0, "rst_z");
    step(0, 1, 1, 4, 4, 1, 0, "prio_load4");
    step(0, 0, 1, 0, 3, 1, 0, "prio_cnt3");
    step(0, 0, 1, 0, 2, 1, 0, "prio_cnt2");
    step(0, 1, 1, 5, 5, 1, 0, "prio_load5");
    step(0, 0, 1, 0, 4, 1, 0, "prio_cnt4");
    step(0, 0, 0, 0, 4, 1, 0, "prio_hold");
    step(1, 0, 0, 0, 0, 0, 0, "rst_prio");
    step(0, 1, 1, 9, 9, 1, 0, "mid_load9");
    step(0, 0, 1, 0, 8, 1, 0, "mid_8");
    step(0, 0, 1, 0, 7, 1, 0, "mid_7");
    step(0, 0, 1, 0, 6, 1, 0, "mid_6");
    step(1, 0, 1, 0, 0, 0, 0, "mid_reset");
    for (int k = 0; k < 8; k++) step(0, 0, 1, 0, 0, 0, 0, "mid_no_done");
    step(0, 1, 1, 2, 2, 1, 0, "ar_load2");
    step(0, 0, 1, 0, 1, 1, 0, "ar_1");
    step(0, 0, 1, 0, 0, 0, 1, "ar_done1");
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    step(0, 0, 1, 0, 2, 1, 0, "ar_reload2");
    step(0, 0, 1, 0, 1, 1, 0, "ar_1b");
    step(0, 0, 1, 0, 0, 0, 1, "ar_done2");
    step(0, 0, 1, 0, 2, 1, 0, "ar_reload3");
`else
    step(0, 0, 1, 0, 0, 0, 0, "ar_idle");
    step(0, 0, 1, 0, 0, 0, 0, "ar_idle2");
    step(0, 0, 1, 0, 0, 0, 0, "ar_idle3");
`endif
    step(1, 0, 0, 0, 0, 0, 0, "rst_ar");
    step(0, 1, 1, 15, 15, 1, 0, "wrap_load15");
    for (int k = 14; k >= 1; k--) step(0, 0, 1, 0, 4'(k), 1, 0, "wrap_cnt");
    step(0, 0, 1, 0, 0, 0, 1, "wrap_done");
    step(1, 0, 0, 0, 0, 0, 0, "rst_wrap");
    for (int k = 0; k < 4; k++) step(0, 0, 1, 0, 0, 0, 0, "idle_en_ignored");
    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (q.size() > 0) begin
      checks++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
